// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and the PCSrc code of interrupt entry.
package irq_ctrl_pkg;

  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h4;
  localparam logic [3:0] OFF_CTRL  = 4'h8;
  localparam logic [3:0] OFF_CAUSE = 4'hC;

  // PCSrc value the ID stage issues when irq_take pulses.
  localparam logic [2:0] PCSRC_IRQ = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_edge_det.sv
// Rising-edge detector for one interrupt line; IRQ_SYNC_EN inserts a
// 2-flop synchronizer ahead of the detector for asynchronous sources.
module irq_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic rise_o
);

  logic src_s;
  logic prev_q;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], src_i};
  end

  assign src_s = sync_q[1];
`else
  assign src_s = src_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= src_s;
  end

  assign rise_o = src_s & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latched, masked, fixed-priority interrupt controller with a 4-word
// register window; optional input synchronizers under IRQ_SYNC_EN.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC      = 4,
  parameter logic [31:0] ADDR_BASE = 32'h4000_0020
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src_irq,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            MemWr,
  input  logic            MemRd,
  output logic [31:0]     rdata,
  output logic            hit,
  input  logic            PC31,
  input  logic            irq_take,
  output logic            IRQ,
  output logic [2:0]      cause_id
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            en_q, en_d;
  logic [2:0]      win_id_q, win_id_d;
  logic [2:0]      cause_id_q, cause_id_d;
  logic            cause_vld_q, cause_vld_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] win_onehot;
  logic [2:0]      win_idx;
  logic            mask_win;
  logic [3:0]      off;
  logic            wr_en, wr_pend, wr_mask, wr_ctrl, wr_cause;
  logic            unused_bits;

  for (genvar g = 0; g < NSRC; g++) begin : g_edge
    irq_edge_det u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .src_i  (src_irq[g]),
      .rise_o (rise[g])
    );
  end

  assign hit      = (addr[31:4] == ADDR_BASE[31:4]);
  assign off      = {addr[3:2], 2'b00};
  assign wr_en    = hit && MemWr;
  assign wr_pend  = wr_en && (off == OFF_PEND);
  assign wr_mask  = wr_en && (off == OFF_MASK);
  assign wr_ctrl  = wr_en && (off == OFF_CTRL);
  assign wr_cause = wr_en && (off == OFF_CAUSE);
  assign eligible = pend_q & mask_q;

  // NOTE: every variable written in always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    mask_win   = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 3'(i);
    end
    for (int i = 0; i < NSRC; i++) begin
      if (win_id_q == 3'(i)) begin
        win_onehot[i] = 1'b1;
        mask_win      = mask_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    win_id_d    = win_id_q;
    cause_id_d  = cause_id_q;
    cause_vld_d = cause_vld_q;
    mask_d      = wr_mask ? wdata[NSRC-1:0] : mask_q;
    en_d        = wr_ctrl ? wdata[0] : en_q;
    pend_d      = wr_pend ? (pend_q & ~wdata[NSRC-1:0]) : pend_q;
    pend_d      = pend_d | rise;  // a fresh edge beats a same-cycle W1C
    if (wr_cause) cause_vld_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q && (|eligible) && !PC31) begin
          state_d  = ST_REQ;
          win_id_d = win_idx;
        end
      end
      ST_REQ: begin
        if (irq_take) begin
          pend_d      = pend_d & ~win_onehot;
          cause_vld_d = 1'b1;
          cause_id_d  = win_id_q;
          state_d     = ST_SERVICE;
        end else if (PC31 || !en_q || !mask_win) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_cause) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      mask_q      <= '0;
      en_q        <= 1'b0;
      win_id_q    <= '0;
      cause_id_q  <= '0;
      cause_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      en_q        <= en_d;
      win_id_q    <= win_id_d;
      cause_id_q  <= cause_id_d;
      cause_vld_q <= cause_vld_d;
    end
  end

  assign IRQ      = (state_q == ST_REQ);
  assign cause_id = cause_id_q;

  always_comb begin
    rdata = '0;
    if (hit && MemRd) begin
      unique case (off)
        OFF_PEND:  rdata[NSRC-1:0] = pend_q;
        OFF_MASK:  rdata[NSRC-1:0] = mask_q;
        OFF_CTRL:  rdata[0]        = en_q;
        OFF_CAUSE: rdata           = {cause_vld_q, 28'b0, cause_id_q};
        default:   rdata           = '0;
      endcase
    end
  end

  assign unused_bits = ^{wdata[31:NSRC], addr[1:0]};

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Peripheral interrupt controller for the pipelined MIPS core.
- Latches edge-triggered interrupt sources, applies mask, global enable and fixed priority, and drives the single IRQ input of the instruction decoder.
- Holds the request until the pipeline commits interrupt entry (PCSrc=100), then records the cause.
- Blocks further requests until the handler writes EOI; software access is through a 4-word memory-mapped window on the data bus.

Parameters:
- NSRC, 4, number of interrupt sources (1..8).
- ADDR_BASE, 32'h40000020, word-aligned base of the register window.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- src_irq  in  NSRC  raw interrupt lines, rising-edge sensitive.
- addr  in  32  data-bus byte address (MEM stage).
- wdata  in  32  store data.
- MemWr  in  1  store strobe.
- MemRd  in  1  load strobe.
- rdata  out  32  load data, combinational.
- hit  out  1  addr falls inside the window (addr[31:4] == ADDR_BASE[31:4]).
- PC31  in  1  kernel-mode bit of the ID-stage PC.
- irq_take  in  1  one-cycle pulse: ID stage issued PCSrc=100 and is not stalled.
- IRQ  out  1  interrupt request to the decoder.
- cause_id  out  3  index of the in-service source.

Behaviour:
- Reset values:
  - All state clears asynchronously: IRQ=0, cause_id=0, PEND=0, MASK=0, EN=0, state=IDLE, edge-history flops=0.
  - rdata=0 and hit=0 for any out-of-window addr.
- Register map (offset, access):
  - 0x0 PEND, read / write-1-to-clear.
  - 0x4 MASK, read/write; 1 = enabled.
  - 0x8 CTRL, bit0 EN.
  - 0xC CAUSE: read returns {valid in bit31, id in bits 2:0}; any write = EOI.
  - Unused bits read 0. Reads are combinational and need hit && MemRd. Writes take effect at the clock edge when hit && MemWr.
- Edge detect: PEND[i] sets on the cycle after src_irq[i] goes 0 to 1. A set and a W1C of the same bit in one cycle: the set wins.
- Winner: lowest index i with PEND[i] && MASK[i].
- FSM IDLE:
  - Go to REQ when EN && any winner && !PC31.
  - Latch win_id; IRQ=1 from the next cycle.
- FSM REQ:
  - IRQ held at 1.
  - irq_take=1: clear PEND[win_id] (overrides a same-cycle set), CAUSE={1,win_id}, cause_id=win_id, go to SERVICE, IRQ=0 next cycle.
  - Otherwise, if PC31=1 (exception or syscall entered first), EN=0, or MASK[win_id]=0: go to IDLE with PEND untouched. irq_take in the same cycle takes priority over this withdrawal.
  - win_id stays frozen in REQ even if a higher-priority source becomes pending.
- FSM SERVICE:
  - IRQ=0; new edges still accumulate in PEND.
  - EOI write: CAUSE.valid=0, go to IDLE. A new request can assert 1 cycle later, subject to PC31.
  - irq_take is ignored outside REQ.
- Latency: src edge to IRQ high is 2 cycles with no sync; add 2 with IRQ_SYNC_EN.
- Reset mid-REQ or mid-SERVICE discards all pending and in-service state.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: each src_irq bit passes through a 2-flop synchronizer before edge detection. Sources may be asynchronous; edge-to-PEND latency is 3 cycles.
- Undefined: src_irq must be synchronous to clk; edge-to-PEND latency is 1 cycle.
- Register map and FSM are identical in both builds.

Decomposition:
- Shared package/include: register offsets (PEND=0, MASK=4, CTRL=8, CAUSE=12), FSM state encodings (IDLE=0, REQ=1, SERVICE=2), PCSrc code for interrupt entry (3'b100).
- One sub-module, irq_edge_det: optional synchronizer plus rising-edge detector, one instance per source (generate loop).

Test Plan:
- MASK=4'b0110, EN=1; pulse src_irq[2] then src_irq[1] -> IRQ high, win_id=1; irq_take -> PEND=4'b0100, CAUSE reads 32'h8000_0001; EOI -> IRQ reasserts with win_id=2.
- EN=1, MASK=4'b0001, PC31=1; pulse src_irq[0] -> PEND=1, IRQ stays 0; drop PC31 -> IRQ high 1 cycle later.
- IRQ in REQ; write MASK=0 with irq_take=0 -> back to IDLE, IRQ low, PEND bit kept; same write with irq_take=1 -> SERVICE, bit cleared.
- Rising edge on src_irq[3] in the same cycle as a W1C write of 4'b1000 to PEND -> PEND[3]=1 afterwards.
- During SERVICE pulse src_irq[0] twice -> PEND[0]=1 (single), IRQ stays 0 until EOI.
- Assert rst_n=0 asynchronously mid-REQ -> IRQ, PEND, MASK, EN, CAUSE all 0 immediately, without waiting for a clock edge.
